// File: rtl/stream_arbiter.sv
// Two-source packet-aware stream arbiter with a single registered output stage.
// Idle ties are broken round-robin; once a multi-beat packet starts, its
// source holds the grant until its last beat is accepted.

// Per-source packet counter, wraps with no saturation.
module stream_arbiter_pkt_cnt #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] cnt
);
   // Count accepted end-of-packet beats.
   always_ff @(posedge clk) begin
      if (!rst)     cnt <= '0;
      else if (inc) cnt <= cnt + CNT_WIDTH'(1);
   end
endmodule

module stream_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in0_data,
   input  logic                  in0_valid,
   input  logic                  in0_last,
   output logic                  in0_ready,
   input  logic [DATA_WIDTH-1:0] in1_data,
   input  logic                  in1_valid,
   input  logic                  in1_last,
   output logic                  in1_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  out_last,
   output logic                  out_src,
   input  logic                  out_ready,
   output logic [CNT_WIDTH-1:0]  pkt_cnt0,
   output logic [CNT_WIDTH-1:0]  pkt_cnt1
);
   localparam int NUM_SRC = 2;

   typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

   state_t state, next_state;
   logic   last_src;
   logic   grant;
   logic   load_en;
   logic   xfer;
   logic   xfer_last;

   logic [NUM_SRC-1:0]                 valid_v, last_v, ready_v, xfer_v;
   logic [NUM_SRC-1:0][DATA_WIDTH-1:0] data_v;
   logic [NUM_SRC-1:0][CNT_WIDTH-1:0]  cnt_v;

   assign valid_v   = {in1_valid, in0_valid};
   assign last_v    = {in1_last, in0_last};
   assign data_v    = {in1_data, in0_data};
   assign in0_ready = ready_v[0];
   assign in1_ready = ready_v[1];

   // Output register may take a new beat when empty or being drained.
   assign load_en   = !out_valid || out_ready;
   assign xfer_v    = valid_v & ready_v;
   assign xfer      = |xfer_v;
   assign xfer_last = last_v[grant];

   // State register; reset abandons any lock and re-arms the tie toward source 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         last_src <= 1'b1;
      end else begin
         state <= next_state;
         if (xfer && xfer_last) last_src <= grant;
      end
   end

   // Next state: a non-last beat locks to its source, a last beat releases.
   always_comb begin
      next_state = state;
      if (xfer) begin
         if (xfer_last) next_state = IDLE;
         else           next_state = grant ? LOCK1 : LOCK0;
      end
   end

   // Grant and ready decode; only the granted source ever sees ready.
   always_comb begin
      grant = 1'b0;
      case (state)
         LOCK0:   grant = 1'b0;
         LOCK1:   grant = 1'b1;
         default: begin
            if (valid_v[0] && valid_v[1]) grant = ~last_src;
            else                          grant = valid_v[1];
         end
      endcase
      ready_v = '0;
      if (rst && load_en) ready_v[grant] = 1'b1;
   end

   // Output stage: load on transfer, bubble when drained with nothing new.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_src   <= 1'b0;
      end else if (load_en) begin
         out_valid <= xfer;
         if (xfer) begin
            out_data <= data_v[grant];
            out_last <= xfer_last;
            out_src  <= grant;
         end
      end
   end

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_cnt
      stream_arbiter_pkt_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
         .clk (clk),
         .rst (rst),
         .inc (xfer_v[i] && last_v[i]),
         .cnt (cnt_v[i])
      );
   end

   assign pkt_cnt0 = cnt_v[0];
   assign pkt_cnt1 = cnt_v[1];
endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter: tie round-robin, packet lock,
// back-pressure, counter wrap, mid-packet reset and gaps inside a lock.
module tb_stream_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in0_data, in1_data, out_data;
   logic       in0_valid, in0_last, in0_ready;
   logic       in1_valid, in1_last, in1_ready;
   logic       out_valid, out_last, out_src, out_ready;
   logic [7:0] pkt_cnt0, pkt_cnt1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stream_arbiter #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in0_data  (in0_data),
      .in0_valid (in0_valid),
      .in0_last  (in0_last),
      .in0_ready (in0_ready),
      .in1_data  (in1_data),
      .in1_valid (in1_valid),
      .in1_last  (in1_last),
      .in1_ready (in1_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_src   (out_src),
      .out_ready (out_ready),
      .pkt_cnt0  (pkt_cnt0),
      .pkt_cnt1  (pkt_cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge; inputs are driven and outputs sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational readies settle after an input change.
   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      in0_valid = 1'b0; in1_valid = 1'b0;
      in0_last = 1'b0;  in1_last = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      in0_data = 8'h00; in0_valid = 1'b1; in0_last = 1'b1;
      in1_data = 8'h00; in1_valid = 1'b1; in1_last = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("rst_in0_ready", in0_ready, 0);
      chk("rst_in1_ready", in1_ready, 0);
      tick();
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_src", out_src, 0);
      chk("rst_cnt0", pkt_cnt0, 0);
      chk("rst_cnt1", pkt_cnt1, 0);

      // Tie after reset: alternates src0, src1, src0, src1 at full rate.
      rst = 1'b1;
      in0_data = 8'hA0; in1_data = 8'hB0;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("tie_in0_ready", in0_ready, (i % 2 == 0) ? 1 : 0);
         chk("tie_in1_ready", in1_ready, (i % 2 == 1) ? 1 : 0);
         tick();
         chk("tie_out_valid", out_valid, 1);
         chk("tie_out_src", out_src, i % 2);
         chk("tie_out_data", out_data, (i % 2 == 0) ? 8'hA0 : 8'hB0);
      end
      in0_valid = 1'b0; in1_valid = 1'b0;
      tick();
      chk("tie_drain_valid", out_valid, 0);
      chk("tie_drain_data_hold", out_data, 8'hB0);
      chk("tie_cnt0", pkt_cnt0, 2);
      chk("tie_cnt1", pkt_cnt1, 2);

      // Packet lock: in0 sends 11,22,33 while in1 waits.
      do_reset();
      in1_valid = 1'b1; in1_last = 1'b1; in1_data = 8'hC1;
      in0_valid = 1'b1; in0_last = 1'b0; in0_data = 8'h11;
      tick();
      chk("lock_b1_data", out_data, 8'h11);
      chk("lock_b1_src", out_src, 0);
      in0_data = 8'h22;
      settle();
      chk("lock_b2_in1_ready", in1_ready, 0);
      chk("lock_b2_in0_ready", in0_ready, 1);
      tick();
      chk("lock_b2_data", out_data, 8'h22);
      chk("lock_b2_src", out_src, 0);
      in0_data = 8'h33; in0_last = 1'b1;
      settle();
      chk("lock_b3_in1_ready", in1_ready, 0);
      tick();
      chk("lock_b3_data", out_data, 8'h33);
      chk("lock_b3_last", out_last, 1);
      chk("lock_b3_src", out_src, 0);
      chk("lock_cnt0", pkt_cnt0, 1);
      in0_valid = 1'b0;
      settle();
      chk("lock_in1_ready", in1_ready, 1);
      tick();
      chk("lock_in1_src", out_src, 1);
      chk("lock_in1_data", out_data, 8'hC1);
      chk("lock_cnt1", pkt_cnt1, 1);
      in1_valid = 1'b0;

      // Back-pressure: hold 0xA5 for 4 cycles, then resume immediately.
      do_reset();
      in0_valid = 1'b1; in0_last = 1'b1; in0_data = 8'hA5;
      tick();
      chk("bp_load_data", out_data, 8'hA5);
      in0_data = 8'h5A;
      in1_valid = 1'b1; in1_last = 1'b1; in1_data = 8'hC3;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("bp_in0_ready", in0_ready, 0);
         chk("bp_in1_ready", in1_ready, 0);
         tick();
         chk("bp_hold_data", out_data, 8'hA5);
         chk("bp_hold_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      settle();
      chk("bp_resume_in1_ready", in1_ready, 1);
      chk("bp_resume_in0_ready", in0_ready, 0);
      tick();
      chk("bp_resume_src", out_src, 1);
      chk("bp_resume_data", out_data, 8'hC3);

      // Counter wrap: 256 single-beat packets from in1.
      do_reset();
      in1_valid = 1'b1; in1_last = 1'b1; in1_data = 8'h44;
      for (int i = 0; i < 255; i++) tick();
      chk("wrap_cnt1_ff", pkt_cnt1, 8'hFF);
      tick();
      chk("wrap_cnt1_0", pkt_cnt1, 8'h00);
      chk("wrap_cnt0", pkt_cnt0, 8'h00);
      in1_valid = 1'b0;

      // Mid-packet reset after the 2nd beat of an in1 packet.
      do_reset();
      in0_valid = 1'b1; in0_last = 1'b1; in0_data = 8'h60;
      tick();
      chk("mrst_cnt0_pre", pkt_cnt0, 1);
      in0_valid = 1'b0;
      in1_valid = 1'b1; in1_last = 1'b0; in1_data = 8'h61;
      tick();
      chk("mrst_b1_src", out_src, 1);
      in1_data = 8'h62;
      tick();
      chk("mrst_b2_data", out_data, 8'h62);
      rst = 1'b0;
      settle();
      chk("mrst_in1_ready", in1_ready, 0);
      tick();
      chk("mrst_out_valid", out_valid, 0);
      chk("mrst_cnt0", pkt_cnt0, 0);
      chk("mrst_cnt1", pkt_cnt1, 0);
      rst = 1'b1;
      in0_valid = 1'b1; in0_last = 1'b1; in0_data = 8'h63;
      in1_last = 1'b1;
      settle();
      chk("mrst_tie_in0_ready", in0_ready, 1);
      chk("mrst_tie_in1_ready", in1_ready, 0);
      tick();
      chk("mrst_tie_src", out_src, 0);

      // Gap in lock: in0 drops valid for 2 cycles; in1 stays blocked.
      do_reset();
      in0_valid = 1'b1; in0_last = 1'b0; in0_data = 8'h71;
      in1_valid = 1'b1; in1_last = 1'b1; in1_data = 8'h81;
      tick();
      chk("gap_b1_src", out_src, 0);
      in0_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("gap_in1_ready", in1_ready, 0);
         tick();
         chk("gap_out_valid", out_valid, 0);
      end
      in0_valid = 1'b1; in0_last = 1'b1; in0_data = 8'h72;
      settle();
      chk("gap_in0_ready", in0_ready, 1);
      tick();
      chk("gap_last_data", out_data, 8'h72);
      chk("gap_last_src", out_src, 0);
      in0_valid = 1'b0;
      settle();
      chk("gap_release_in1_ready", in1_ready, 1);
      tick();
      chk("gap_release_src", out_src, 1);
      chk("gap_release_data", out_data, 8'h81);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/stream_arbiter.md
STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
Parameters (name, default, meaning):
- REQ-001 DATA_WIDTH, 8, payload width of every data port in bits.
- REQ-002 CNT_WIDTH, 8, width of each per-source packet counter.

Ports (name, direction, width, meaning):
- REQ-003 clk, input, 1, single clock; every flop is updated on its rising edge.
- REQ-004 rst, input, 1, reset; synchronous and active-low (0 = reset).
- REQ-005 in0_data, input, DATA_WIDTH, source 0 payload.
- REQ-006 in0_valid, input, 1, source 0 beat present.
- REQ-007 in0_last, input, 1, source 0 beat ends a packet.
- REQ-008 in0_ready, output, 1, source 0 beat accepted this cycle.
- REQ-009 in1_data, in1_valid, in1_last (input) and in1_ready (output) SHALL mirror REQ-005..008 for source 1.
- REQ-010 out_data, output, DATA_WIDTH, registered payload.
- REQ-011 out_valid, output, 1, registered beat present.
- REQ-012 out_last, output, 1, registered end-of-packet flag.
- REQ-013 out_src, output, 1, index of the source that supplied the registered beat.
- REQ-014 out_ready, input, 1, sink accepts the beat.
- REQ-015 pkt_cnt0, output, CNT_WIDTH, number of packets accepted from source 0.
- REQ-016 pkt_cnt1, output, CNT_WIDTH, number of packets accepted from source 1.

Function
- REQ-017 A transfer SHALL occur on a port in any cycle where valid and ready are both 1.
- REQ-018 The output stage SHALL be a single register. load_en = !out_valid || out_ready.
- REQ-019 in0_ready and in1_ready SHALL be combinational. inX_ready = load_en && (grant == X) && arbitration permits X. At most one SHALL be 1 in any cycle.
- REQ-020 The FSM SHALL have three states: IDLE, LOCK0 and LOCK1.
- REQ-021 In IDLE, the grant SHALL be chosen as follows:
  - only one source valid: that source;
  - both sources valid: the source that is not last_src (round-robin).
- REQ-022 An accepted beat with last=0 SHALL move the FSM to LOCKx for the granting source x.
- REQ-023 In LOCKx, only source x SHALL be granted, whatever the other source's valid.
- REQ-024 An accepted beat with last=1 SHALL return the FSM to IDLE and set last_src to x.
- REQ-025 A single-beat packet (last=1 accepted from IDLE) SHALL stay in IDLE and update last_src.
- REQ-026 On a transfer from source x, the output register SHALL load, on the next edge:
  - out_data <= inx_data, out_last <= inx_last, out_src <= x;
  - out_valid <= 1.
- REQ-027 If load_en=1 and no input transfer occurs, out_valid SHALL be 0 on the next edge. out_data, out_last and out_src SHALL hold their values.
- REQ-028 If load_en=0, all output registers SHALL hold. out_* SHALL be stable while out_valid=1 and out_ready=0.
- REQ-029 Latency from input transfer to out_valid=1 SHALL be exactly 1 cycle.
- REQ-030 Sustained throughput SHALL be 1 beat per cycle while out_ready=1.
- REQ-031 pkt_cntx SHALL increment by 1 on each accepted source x beat with last=1. It SHALL wrap modulo 2^CNT_WIDTH with no saturation.
- REQ-032 Input valid may drop in LOCKx before last. The FSM SHALL stay in LOCKx and the other source SHALL stay blocked.
- REQ-033 Simultaneous output drain (out_ready=1) and new input transfer SHALL replace the register contents in the same edge, with no bubble.

Reset
- REQ-034 While rst=0 at a clock edge, the following SHALL be set on that edge:
  - FSM = IDLE, last_src = 1;
  - out_valid = 0, out_data = 0, out_last = 0, out_src = 0;
  - pkt_cnt0 = 0, pkt_cnt1 = 0.
- REQ-035 in0_ready and in1_ready SHALL be 0 during any cycle with rst=0.
- REQ-036 Reset asserted mid-packet SHALL abandon the lock and discard any registered beat. The first post-reset tie SHALL be granted to source 0.

Verification
- REQ-037 Tie after reset: in0 and in1 both valid, last=1, out_ready=1.
  - out sequence: src0, src1, src0, src1, one beat per cycle, first out_valid 1 cycle after first accept.
- REQ-038 Packet lock: in0 sends a 3-beat packet (data 0x11, 0x22, 0x33 with last on 0x33) while in1 is valid throughout.
  - out_src = 0 for all three beats, then the in1 beat follows.
  - pkt_cnt0 = 1.
- REQ-039 Back-pressure: out_ready=0 for 4 cycles while holding out_data = 0xA5.
  - out_data stays 0xA5 and out_valid stays 1.
  - in0_ready = in1_ready = 0 for those cycles.
  - Accept resumes the cycle out_ready returns to 1.
- REQ-040 Counter wrap: 256 single-beat packets from in1.
  - pkt_cnt1 returns to 0x00; pkt_cnt0 stays 0.
- REQ-041 Mid-packet reset: rst=0 for 1 cycle after the 2nd beat of an in1 packet.
  - Next edge: out_valid = 0, pkt counters = 0.
  - After reset, a tie grants in0.
- REQ-042 Gap in lock: in0 valid drops for 2 cycles mid-packet while in1 is valid.
  - in1_ready stays 0 and no out beat is issued with out_src = 1 until in0's last beat.
